// File: rtl/cache_pkg.sv
// Shared types and address-split width helpers for the set-associative write-back cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    function automatic int offset_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int block_words, input int sets);
        return 32 - $clog2(block_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age update and victim choice for one set; shared across sets by an index mux in the top.
module cache_lru_set #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0][$clog2(WAYS)-1:0] ages,
    input  logic [WAYS-1:0]                   valid,
    input  logic [$clog2(WAYS)-1:0]           access_way,
    output logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_next,
    output logic [$clog2(WAYS)-1:0]           victim_way
);
    localparam int AW = $clog2(WAYS);

    logic [AW-1:0] access_age;
    assign access_age = ages[access_way];

    // Accessed way becomes youngest; only ways younger than it age by one, keeping a permutation.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
            assign ages_next[gi] = (AW'(gi) == access_way) ? '0 :
                                   (ages[gi] < access_age)  ? ages[gi] + 1'b1 :
                                                              ages[gi];
        end
    endgenerate

    // Descending scans so the lowest-index invalid way wins over the oldest way.
    always_comb begin
        victim_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ages[w] == AW'(WAYS - 1)) victim_way = AW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim_way = AW'(w);
        end
    end

endmodule

// File: rtl/set_assoc_wb_cache.sv
// Set-associative write-back, write-allocate cache with true-LRU replacement.
// Define CACHE_STATS_EN to build saturating hit/miss counters; otherwise they read constant 0.
module set_assoc_wb_cache
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int WAYS        = 4,
    parameter int SETS        = 64
) (
    input  logic                                 CLOCK,
    input  logic                                 RESET,
    input  logic                                 READ_EN,
    input  logic                                 WRITE_EN,
    input  logic [31:0]                          ADDR,
    input  logic [31:0]                          WRITE_DATA,
    output logic [31:0]                          READ_DATA,
    output logic                                 BUSYWAIT,
    output logic                                 MEM_READ_EN,
    output logic                                 MEM_WRITE_EN,
    output logic [31-offset_bits(BLOCK_WORDS):0] MEM_ADDR,
    output logic [32*BLOCK_WORDS-1:0]            MEM_WRITE_DATA,
    input  logic [32*BLOCK_WORDS-1:0]            MEM_READ_DATA,
    input  logic                                 MEM_BUSYWAIT,
    output logic [31:0]                          HIT_COUNT,
    output logic [31:0]                          MISS_COUNT
);
    localparam int OB = offset_bits(BLOCK_WORDS);
    localparam int IB = index_bits(SETS);
    localparam int TB = tag_bits(BLOCK_WORDS, SETS);
    localparam int AW = $clog2(WAYS);

    // Data and tags need no reset: valid bits gate every use of them.
    logic [31:0]   data_mem [SETS][WAYS][BLOCK_WORDS];
    logic [TB-1:0] tag_mem  [SETS][WAYS];

    logic [SETS-1:0][WAYS-1:0]         valid_reg;
    logic [SETS-1:0][WAYS-1:0]         dirty_reg;
    logic [SETS-1:0][WAYS-1:0][AW-1:0] age_reg;

    cache_state_t  state_reg, state_next;
    logic [AW-1:0] victim_reg;
    logic [TB-1:0] tag_reg;
    logic [TB-1:0] victim_tag_reg;
    logic [IB-1:0] index_reg;
    logic [31:0]   read_data_reg;

    logic [OB-1:0] offset;
    logic [IB-1:0] index;
    logic [TB-1:0] tag;
    logic          req;
    logic [WAYS-1:0] way_match;
    logic [AW-1:0] hit_way;
    logic          hit;
    logic          idle_hit;
    logic [31:0]   hit_word;
    logic          miss_start;
    logic          wb_done;
    logic          fill_done;

    logic [IB-1:0]                 lru_index;
    logic [AW-1:0]                 lru_access;
    logic [WAYS-1:0][AW-1:0]       lru_ages_next;
    logic [AW-1:0]                 lru_victim;

    assign offset = ADDR[OB-1:0];
    assign index  = ADDR[OB +: IB];
    assign tag    = ADDR[31 -: TB];
    assign req    = READ_EN | WRITE_EN;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign way_match[gi] = valid_reg[index][gi] && (tag_mem[index][gi] == tag);
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) hit_way = AW'(w);
        end
    end

    assign hit       = req & (|way_match);
    assign idle_hit  = hit && (state_reg == IDLE);
    assign BUSYWAIT  = req & ~idle_hit;
    assign hit_word  = data_mem[index][hit_way][offset];
    assign READ_DATA = (READ_EN && idle_hit) ? hit_word : read_data_reg;

    // In IDLE the LRU unit serves the live request; during a miss it serves the latched set.
    assign lru_index  = (state_reg == IDLE) ? index   : index_reg;
    assign lru_access = (state_reg == IDLE) ? hit_way : victim_reg;

    cache_lru_set #(
        .WAYS(WAYS)
    ) u_lru (
        .ages      (age_reg[lru_index]),
        .valid     (valid_reg[lru_index]),
        .access_way(lru_access),
        .ages_next (lru_ages_next),
        .victim_way(lru_victim)
    );

    always_comb begin
        state_next = state_reg;
        miss_start = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && !hit) begin
                    miss_start = 1'b1;
                    state_next = (valid_reg[index][lru_victim] && dirty_reg[index][lru_victim])
                                 ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    wb_done    = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (!MEM_BUSYWAIT) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign MEM_READ_EN  = (state_reg == ALLOCATE);
    assign MEM_WRITE_EN = (state_reg == WRITEBACK);
    assign MEM_ADDR     = (state_reg == WRITEBACK) ? {victim_tag_reg, index_reg}
                                                   : {tag_reg, index_reg};

    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_wb_data
            assign MEM_WRITE_DATA[32*gi +: 32] = data_mem[index_reg][victim_reg][gi];
        end
    endgenerate

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            dirty_reg      <= '0;
            victim_reg     <= '0;
            tag_reg        <= '0;
            victim_tag_reg <= '0;
            index_reg      <= '0;
            read_data_reg  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_reg[s][w] <= AW'(w);
                end
            end
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                victim_reg     <= lru_victim;
                tag_reg        <= tag;
                index_reg      <= index;
                victim_tag_reg <= tag_mem[index][lru_victim];
            end
            if (idle_hit) begin
                age_reg[index] <= lru_ages_next;
                if (READ_EN)  read_data_reg <= hit_word;
                if (WRITE_EN) dirty_reg[index][hit_way] <= 1'b1;
            end
            if (wb_done) dirty_reg[index_reg][victim_reg] <= 1'b0;
            if (fill_done) begin
                valid_reg[index_reg][victim_reg] <= 1'b1;
                dirty_reg[index_reg][victim_reg] <= 1'b0;
                age_reg[index_reg]               <= lru_ages_next;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (idle_hit && WRITE_EN) begin
            data_mem[index][hit_way][offset] <= WRITE_DATA;
        end
        if (fill_done) begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                data_mem[index_reg][victim_reg][w] <= MEM_READ_DATA[32*w +: 32];
            end
            tag_mem[index_reg][victim_reg] <= tag_reg;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;
    logic        refill_reg;

    // The hit that completes a refilled request is not a first-lookup hit.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
            refill_reg     <= 1'b0;
        end else begin
            refill_reg <= fill_done;
            if (idle_hit && !refill_reg && (hit_count_reg != '1)) hit_count_reg <= hit_count_reg + 1'b1;
            if (miss_start && (miss_count_reg != '1)) miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign HIT_COUNT  = hit_count_reg;
    assign MISS_COUNT = miss_count_reg;
`else
    assign HIT_COUNT  = '0;
    assign MISS_COUNT = '0;
`endif

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Scoreboard bench for set_assoc_wb_cache against a flat reference memory and a latency memory model.
module tb_set_assoc_wb_cache;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int MEM_LAT = 2;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         READ_EN = 1'b0;
    logic         WRITE_EN = 1'b0;
    logic [31:0]  ADDR = '0;
    logic [31:0]  WRITE_DATA = '0;
    logic [31:0]  READ_DATA;
    logic         BUSYWAIT;
    logic         MEM_READ_EN;
    logic         MEM_WRITE_EN;
    logic [29:0]  MEM_ADDR;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] MEM_READ_DATA = '0;
    logic         MEM_BUSYWAIT = 1'b1;
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;

    always #5 CLOCK = ~CLOCK;

    set_assoc_wb_cache dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .READ_EN       (READ_EN),
        .WRITE_EN      (WRITE_EN),
        .ADDR          (ADDR),
        .WRITE_DATA    (WRITE_DATA),
        .READ_DATA     (READ_DATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ_EN   (MEM_READ_EN),
        .MEM_WRITE_EN  (MEM_WRITE_EN),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_READ_DATA (MEM_READ_DATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] bk_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if ((a >> 2) == 32'h40) begin
            case (a[1:0])
                2'd0: return 32'hDDDDCCCC;
                2'd1: return 32'hBBBBAAAA;
                2'd2: return 32'h22221111;
                default: return 32'h44443333;
            endcase
        end
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (bk_mem.exists(a)) return bk_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Memory model: MEM_LAT stall cycles per strobe, then one ready cycle.
    int           mem_cnt = 0;
    bit           mem_stall = 1'b0;
    int           n_rd = 0, n_wr = 0, mem_seq = 0, last_rd_seq = 0, last_wr_seq = 0;
    logic [29:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;

    always @(negedge CLOCK) begin
        if (MEM_READ_EN && MEM_WRITE_EN) check("mem_both_strobes", 32'd1, 32'd0);
        if (RESET) begin
            mem_cnt = 0;
            MEM_BUSYWAIT = 1'b1;
        end else if (MEM_READ_EN || MEM_WRITE_EN) begin
            if (mem_stall || mem_cnt < MEM_LAT) begin
                MEM_BUSYWAIT = 1'b1;
                mem_cnt++;
            end else begin
                MEM_BUSYWAIT = 1'b0;
                mem_cnt = 0;
                mem_seq++;
                if (MEM_WRITE_EN) begin
                    n_wr++;
                    last_wr_addr = MEM_ADDR;
                    last_wr_data = MEM_WRITE_DATA;
                    last_wr_seq  = mem_seq;
                    for (int i = 0; i < 4; i++) bk_mem[{MEM_ADDR, 2'(i)}] = MEM_WRITE_DATA[32*i +: 32];
                end else begin
                    n_rd++;
                    last_rd_addr = MEM_ADDR;
                    last_rd_seq  = mem_seq;
                    for (int i = 0; i < 4; i++) MEM_READ_DATA[32*i +: 32] = mem_word({MEM_ADDR, 2'(i)});
                end
            end
        end else begin
            MEM_BUSYWAIT = 1'b1;
            mem_cnt = 0;
        end
    end

    int t_rd, t_wr;
    bit t_stall;

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int r0, w0, cyc;
        logic [31:0] exp;
        @(negedge CLOCK);
        r0 = n_rd;
        w0 = n_wr;
        cyc = 0;
        READ_EN = !wr;
        WRITE_EN = wr;
        ADDR = a;
        WRITE_DATA = d;
        if (wr) ref_mem[a] = d;
        else exp_q.push_back(ref_word(a));
        t_stall = 1'b0;
        #1;
        while (BUSYWAIT && cyc < 200) begin
            t_stall = 1'b1;
            cyc++;
            @(negedge CLOCK);
            #1;
        end
        check($sformatf("busy_bound@%h", a), {31'd0, BUSYWAIT}, 32'd0);
        if (!wr) begin
            exp = exp_q.pop_front();
            check($sformatf("rd@%h", a), READ_DATA, exp);
        end
        @(posedge CLOCK);
        #1;
        READ_EN = 1'b0;
        WRITE_EN = 1'b0;
        t_rd = n_rd - r0;
        t_wr = n_wr - w0;
        $display("[TB] %s addr=%h data=%h stall=%0d mem_rd=%0d mem_wr=%0d",
                 wr ? "WR" : "RD", a, wr ? d : READ_DATA, t_stall, t_rd, t_wr);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        READ_EN = 1'b0;
        WRITE_EN = 1'b0;
        mem_stall = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        ref_mem = bk_mem;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (2) @(negedge CLOCK);
        #1;
        check("rst_read_data", READ_DATA, 32'd0);
        check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("rst_mem_rd", {31'd0, MEM_READ_EN}, 32'd0);
        check("rst_mem_wr", {31'd0, MEM_WRITE_EN}, 32'd0);
        check("rst_hit_cnt", HIT_COUNT, 32'd0);
        check("rst_miss_cnt", MISS_COUNT, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Cold miss fill
        access(1'b0, 32'h100, 32'd0);
        check("cold_mem_rd", t_rd, 1);
        check("cold_mem_addr", {2'b0, last_rd_addr}, 32'h40);
        check("cold_data_held", READ_DATA, 32'hDDDDCCCC);
        check("cold_miss_cnt", MISS_COUNT, STATS ? 32'd1 : 32'd0);

        // Write hit then read hit, no stalls or traffic
        access(1'b1, 32'h101, 32'hDEADBEEF);
        check("wrhit_stall", {31'd0, t_stall}, 32'd0);
        check("wrhit_traffic", t_rd + t_wr, 0);
        access(1'b0, 32'h101, 32'd0);
        check("rdhit_stall", {31'd0, t_stall}, 32'd0);
        check("rdhit_traffic", t_rd + t_wr, 0);
        check("hit_cnt", HIT_COUNT, STATS ? 32'd2 : 32'd0);

        // Reset while ALLOCATE is stalled
        mem_stall = 1'b1;
        @(negedge CLOCK);
        READ_EN = 1'b1;
        ADDR = 32'h200;
        repeat (3) @(negedge CLOCK);
        #1;
        check("stall_in_alloc", {31'd0, MEM_READ_EN}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_drops_rd_en", {31'd0, MEM_READ_EN}, 32'd0);
        check("rst_drops_wr_en", {31'd0, MEM_WRITE_EN}, 32'd0);
        check("rst_miss_clear", MISS_COUNT, 32'd0);
        @(negedge CLOCK);
        READ_EN = 1'b0;
        mem_stall = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        ref_mem = bk_mem;
        access(1'b0, 32'h100, 32'd0);
        check("post_rst_remiss", t_rd, 1);

        // LRU: fill set 0, fifth tag evicts oldest
        do_reset();
        for (int i = 0; i < 4; i++) access(1'b0, 32'(i) << 8, 32'd0);
        access(1'b0, 32'h400, 32'd0);
        check("lru_a_400_miss", t_rd, 1);
        check("lru_a_no_wb", t_wr, 0);
        access(1'b0, 32'h100, 32'd0);
        check("lru_a_100_kept", t_rd, 0);
        access(1'b0, 32'h000, 32'd0);
        check("lru_a_000_evicted", t_rd, 1);

        // LRU: touching 0x000 first moves eviction to 0x100
        do_reset();
        for (int i = 0; i < 4; i++) access(1'b0, 32'(i) << 8, 32'd0);
        access(1'b0, 32'h000, 32'd0);
        check("lru_b_000_hit", t_rd, 0);
        access(1'b0, 32'h400, 32'd0);
        access(1'b0, 32'h000, 32'd0);
        check("lru_b_000_kept", t_rd, 0);
        access(1'b0, 32'h100, 32'd0);
        check("lru_b_100_evicted", t_rd, 1);

        // Dirty eviction writes back before the refill
        do_reset();
        access(1'b1, 32'h001, 32'hCAFEF00D);
        check("wrmiss_alloc", t_rd, 1);
        for (int i = 1; i < 4; i++) access(1'b0, 32'(i) << 8, 32'd0);
        access(1'b0, 32'h400, 32'd0);
        check("wb_count", t_wr, 1);
        check("wb_addr", {2'b0, last_wr_addr}, 32'h0);
        check("wb_word1", last_wr_data[63:32], 32'hCAFEF00D);
        check("wb_word0", last_wr_data[31:0], init_word(32'h0));
        check("wb_then_rd", {31'd0, last_rd_seq > last_wr_seq}, 32'd1);
        check("wb_fill_addr", {2'b0, last_rd_addr}, 32'h100);
        access(1'b0, 32'h001, 32'd0);

        // Random mixed traffic over two sets and eight tags
        do_reset();
        for (int i = 0; i < 60; i++) begin
            a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 1)) << 2)
                | 32'($urandom_range(0, 3));
            access($urandom_range(0, 9) < 4, a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/set_assoc_wb_cache.md
SET_ASSOC_WB_CACHE -- requirements
Module: set_assoc_wb_cache

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4, meaning 32-bit words per block (power of 2, >=2).
REQ-002 SHALL have parameter WAYS, default 4, meaning ways per set (power of 2, >=2).
REQ-003 SHALL have parameter SETS, default 64, meaning number of sets (power of 2).
REQ-004 SHALL have port CLOCK, input, 1, system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have ports READ_EN and WRITE_EN, input, 1 each, CPU request strobes; both high is illegal.
REQ-007 SHALL have port ADDR, input, 32, CPU word address split {tag, index, offset}, with OFFSET_BITS=clog2(BLOCK_WORDS) and INDEX_BITS=clog2(SETS).
REQ-008 SHALL have ports WRITE_DATA (input, 32) and READ_DATA (output, 32), the CPU data.
REQ-009 SHALL have port BUSYWAIT, output, 1, CPU stall.
REQ-010 SHALL have ports MEM_READ_EN and MEM_WRITE_EN, output, 1 each, memory strobes.
REQ-011 SHALL have port MEM_ADDR, output, 32-OFFSET_BITS, block address.
REQ-012 SHALL have ports MEM_WRITE_DATA (output) and MEM_READ_DATA (input), 32*BLOCK_WORDS each, with word i at bits [32i+:32].
REQ-013 SHALL have port MEM_BUSYWAIT, input, 1, memory stall.
REQ-014 SHALL have ports HIT_COUNT and MISS_COUNT, output, 32 each, statistics (see Configuration).

Function
REQ-015 Hit SHALL mean the request is active and a valid way in set[index] has a matching tag; lookup is combinational.
REQ-016 BUSYWAIT SHALL equal (READ_EN|WRITE_EN) & ~(hit & state==IDLE), combinationally.
REQ-017 On a read hit, READ_DATA SHALL present word[offset] of the hit way in the same cycle (zero latency); otherwise it holds its last value.
REQ-018 On a write hit, the word SHALL be written and the line marked dirty at the next CLOCK edge, with no memory traffic.
REQ-019 The FSM SHALL have states IDLE, WRITEBACK and ALLOCATE.
REQ-020 In IDLE on a miss, the FSM SHALL go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
REQ-021 In WRITEBACK, MEM_WRITE_EN=1, MEM_ADDR={victim tag, index} and MEM_WRITE_DATA=victim block SHALL be held; when MEM_BUSYWAIT=0, the FSM SHALL clear dirty and go to ALLOCATE.
REQ-022 In ALLOCATE, MEM_READ_EN=1 and MEM_ADDR={tag, index} SHALL be held; when MEM_BUSYWAIT=0, the FSM SHALL store MEM_READ_DATA, tag, valid=1, dirty=0, then return to IDLE, where the request completes as a hit.
REQ-023 MEM strobes SHALL be registered-state driven: low in IDLE, never both high.
REQ-024 Victim selection SHALL pick the lowest-index invalid way; if all ways are valid, it SHALL pick the way with the maximum LRU age.
REQ-025 LRU SHALL be true LRU with per-way ages of clog2(WAYS) bits; on a hit or fill, the accessed way's age SHALL become 0 and ways with a smaller age SHALL increment, so ages stay a permutation 0..WAYS-1.
REQ-026 Victim way, tag and index SHALL be latched on leaving IDLE; ADDR changes during a miss SHALL NOT redirect the fill.

Reset
REQ-027 RESET SHALL asynchronously set state=IDLE, all valid and dirty bits to 0, ages to way index, MEM_READ_EN=MEM_WRITE_EN=0, READ_DATA=0 and counters to 0; a transaction in flight SHALL be abandoned.

Configuration
REQ-028 With CACHE_STATS_EN defined, HIT_COUNT SHALL increment on each completed request that hits on first lookup, and MISS_COUNT SHALL increment once per miss on leaving IDLE; both saturate at all-ones.
REQ-029 Without CACHE_STATS_EN, both counters SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-030 A package cache_pkg SHALL hold the state enum and the OFFSET/INDEX/TAG width functions.
REQ-031 LRU age update and victim selection SHALL be a sub-module cache_lru_set, instantiated per set or shared with an index mux.

Verification (defaults; tag=ADDR[31:8], index=ADDR[7:2])
REQ-032 After reset, read ADDR=0x100 SHALL produce MEM_READ_EN with MEM_ADDR=0x40; the memory returns 0x44443333_22221111_BBBBAAAA_DDDDCCCC; READ_DATA SHALL be 0xDDDDCCCC with BUSYWAIT low and MISS_COUNT=1.
REQ-033 Write 0xDEADBEEF to 0x101 (hit) then read 0x101 SHALL return 0xDEADBEEF with BUSYWAIT never high and no MEM strobe.
REQ-034 Reading 0x000, 0x100, 0x200, 0x300, then 0x400 SHALL evict the 0x000 line; re-reading 0x000 before the 0x400 access SHALL instead evict 0x100.
REQ-035 Writing 0x001 dirty then forcing its eviction SHALL produce MEM_WRITE_EN with MEM_ADDR=0x00 and the written word at bits [63:32], followed by MEM_READ_EN.
REQ-036 RESET pulsed during ALLOCATE with MEM_BUSYWAIT=1 SHALL immediately drop MEM_READ_EN, and a later read of 0x100 SHALL miss again.
